// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline types for the decode/execute boundary: the control bundle
// carried from decode into execute, the hardwired-zero register index and
// the all-zero control word that marks a bubble.
package riscv_pipe_pkg;

  typedef struct packed {
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
    logic       memToReg;
    logic       aluSrc;
    logic       branch;
    logic [1:0] aluOp;
  } ctrl_t;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam ctrl_t      CTRL_NOP = 8'h00;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard compare: a load sitting in EX whose destination is read by
// the valid instruction in decode. x0 never creates a dependency.
module hazard_detect #(
  parameter int ADDRW = 5
) (
  input  logic             i_valid_d,
  input  logic             i_valid_e,
  input  logic             i_mem_read_e,
  input  logic [ADDRW-1:0] i_rd_e,
  input  logic [ADDRW-1:0] i_rs1_d,
  input  logic [ADDRW-1:0] i_rs2_d,
  input  logic             i_use_rs1_d,
  input  logic             i_use_rs2_d,
  output logic             o_hz
);
  import riscv_pipe_pkg::*;

  logic w_rd_nz;
  logic w_hit1;
  logic w_hit2;

  assign w_rd_nz = (i_rd_e != ADDRW'(REG_ZERO));
  assign w_hit1  = i_use_rs1_d & (i_rs1_d == i_rd_e);
  assign w_hit2  = i_use_rs2_d & (i_rs2_d == i_rd_e);
  assign o_hz    = i_valid_e & i_mem_read_e & w_rd_nz & (w_hit1 | w_hit2) & i_valid_d;

endmodule

// File: rtl/id_ex_stage.sv
// Decode->execute pipeline register. Captures operands straight from the
// register-file read ports, stalls decode for one cycle on a load-use
// dependency (inserting a bubble), kills the decode slot on redirect and
// keeps a saturating stall-cycle counter.
// Optional build macro: WB_BYPASS_EN -- when defined, an operand whose
// source register is being written by WB in the same cycle is taken from
// wbDataWrite instead of the register-file read data.
module id_ex_stage
  import riscv_pipe_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int ADDRW = 5,
  parameter int PCW   = 64,
  parameter int CNTW  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             validD,
  input  logic [PCW-1:0]   pcD,
  input  logic [ADDRW-1:0] rs1D,
  input  logic [ADDRW-1:0] rs2D,
  input  logic             useRs1D,
  input  logic             useRs2D,
  input  logic [ADDRW-1:0] rdD,
  input  logic [WIDTH-1:0] immD,
  input  ctrl_t            ctrlD,
  input  logic [WIDTH-1:0] readData1,
  input  logic [WIDTH-1:0] readData2,
  input  logic             wbRegWrite,
  input  logic [ADDRW-1:0] wbWriteReg,
  input  logic [WIDTH-1:0] wbDataWrite,
  input  logic             flush,
  output logic             stallFD,
  output logic             validE,
  output logic [PCW-1:0]   pcE,
  output logic [ADDRW-1:0] rs1E,
  output logic [ADDRW-1:0] rs2E,
  output logic [ADDRW-1:0] rdE,
  output logic [WIDTH-1:0] immE,
  output ctrl_t            ctrlE,
  output logic [WIDTH-1:0] opA_E,
  output logic [WIDTH-1:0] opB_E,
  output logic [CNTW-1:0]  stallCount
);

  logic             r_valid_e;
  logic [PCW-1:0]   r_pc_e;
  logic [ADDRW-1:0] r_rs1_e;
  logic [ADDRW-1:0] r_rs2_e;
  logic [ADDRW-1:0] r_rd_e;
  logic [WIDTH-1:0] r_imm_e;
  ctrl_t            r_ctrl_e;
  logic [WIDTH-1:0] r_opa_e;
  logic [WIDTH-1:0] r_opb_e;
  logic [CNTW-1:0]  r_stall_cnt;

  logic             w_hz;
  logic             w_byp1;
  logic             w_byp2;
  logic [WIDTH-1:0] w_opa;
  logic [WIDTH-1:0] w_opb;
  logic [ADDRW-1:0] w_zero;

  assign w_zero = ADDRW'(REG_ZERO);

  hazard_detect #(.ADDRW(ADDRW)) u_hazard_detect (
    .i_valid_d    (validD),
    .i_valid_e    (r_valid_e),
    .i_mem_read_e (r_ctrl_e.memRead),
    .i_rd_e       (r_rd_e),
    .i_rs1_d      (rs1D),
    .i_rs2_d      (rs2D),
    .i_use_rs1_d  (useRs1D),
    .i_use_rs2_d  (useRs2D),
    .o_hz         (w_hz)
  );

  // A redirect wins over a stall: the dependent instruction is being killed anyway.
  assign stallFD = w_hz & ~flush;

`ifdef WB_BYPASS_EN
  assign w_byp1 = wbRegWrite & (wbWriteReg == rs1D) & (rs1D != w_zero);
  assign w_byp2 = wbRegWrite & (wbWriteReg == rs2D) & (rs2D != w_zero);
`else
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
  logic w_unused_wb;
  assign w_unused_wb = ^{wbRegWrite, wbWriteReg, wbDataWrite};
`endif

  // Operand select: x0 reads as zero, else optional WB bypass, else regfile data.
  always_comb begin
    w_opa = readData1;
    w_opb = readData2;
    if (rs1D == w_zero) begin
      w_opa = {WIDTH{1'b0}};
    end else if (w_byp1) begin
      w_opa = wbDataWrite;
    end else begin
      w_opa = readData1;
    end
    if (rs2D == w_zero) begin
      w_opb = {WIDTH{1'b0}};
    end else if (w_byp2) begin
      w_opb = wbDataWrite;
    end else begin
      w_opb = readData2;
    end
  end

  // EX pipeline register: bubble on flush or load-use, otherwise capture decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid_e <= 1'b0;
      r_ctrl_e  <= CTRL_NOP;
      r_pc_e    <= {PCW{1'b0}};
      r_rs1_e   <= {ADDRW{1'b0}};
      r_rs2_e   <= {ADDRW{1'b0}};
      r_rd_e    <= {ADDRW{1'b0}};
      r_imm_e   <= {WIDTH{1'b0}};
      r_opa_e   <= {WIDTH{1'b0}};
      r_opb_e   <= {WIDTH{1'b0}};
    end else if (flush || w_hz) begin
      r_valid_e <= 1'b0;
      r_ctrl_e  <= CTRL_NOP;
    end else begin
      r_valid_e <= validD;
      r_ctrl_e  <= validD ? ctrlD : CTRL_NOP;
      r_pc_e    <= pcD;
      r_rs1_e   <= rs1D;
      r_rs2_e   <= rs2D;
      r_rd_e    <= rdD;
      r_imm_e   <= immD;
      r_opa_e   <= w_opa;
      r_opb_e   <= w_opb;
    end
  end

  // Saturating count of load-use stall cycles that were not overridden by a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= {CNTW{1'b0}};
    end else if (stallFD && (r_stall_cnt != {CNTW{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + {{(CNTW-1){1'b0}}, 1'b1};
    end
  end

  assign validE     = r_valid_e;
  assign pcE        = r_pc_e;
  assign rs1E       = r_rs1_e;
  assign rs2E       = r_rs2_e;
  assign rdE        = r_rd_e;
  assign immE       = r_imm_e;
  assign ctrlE      = r_ctrl_e;
  assign opA_E      = r_opa_e;
  assign opB_E      = r_opb_e;
  assign stallCount = r_stall_cnt;

endmodule
